tmds_decoder: RTL and testbench

TMDS_DECODER -- requirements
Module: tmds_decoder

---
 rtl/tmds_decoder.sv | 174 +++++++++++++++++
 tb/tb_tmds_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_decoder.sv
// TMDS channel decoder with control-token word alignment (bitslip search) and a 2-stage decode pipeline.
// Optional loss_count output is enabled by defining TMDS_DEC_LOSSCNT_EN.
`timescale 1ns/1ps
module tmds_decoder #(
    parameter int WINDOW      = 4096,
    parameter int TOKEN_RUN   = 8,
    parameter int SETTLE_CYC  = 16,
    parameter int LOSS_WINDOW = 1048576
) (
    input  logic       pixclk,
    input  logic       rst_n,
    input  logic [9:0] tmds_in,
    output logic       bitslip,
    output logic       locked,
    output logic [7:0] VD,
    output logic [1:0] CD,
    output logic       VDE
`ifdef TMDS_DEC_LOSSCNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    localparam int WIN_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int RUN_W  = $clog2(TOKEN_RUN + 1);
    localparam int SET_W  = $clog2(SETTLE_CYC + 1);
    localparam int LOSS_W = (LOSS_WINDOW > 1) ? $clog2(LOSS_WINDOW) : 1;

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] SLIP   = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;
    localparam logic [1:0] LOCKED = 2'd3;

    function automatic logic is_token(input logic [9:0] s);
        return (s == 10'b1101010100) || (s == 10'b0010101011) ||
               (s == 10'b0101010100) || (s == 10'b1010101011);
    endfunction

    function automatic logic [1:0] token_cd(input logic [9:0] s);
        case (s)
            10'b0010101011: token_cd = 2'b01;
            10'b0101010100: token_cd = 2'b10;
            10'b1010101011: token_cd = 2'b11;
            default:        token_cd = 2'b00;
        endcase
    endfunction

    logic [1:0]        state;
    logic [RUN_W-1:0]  run;
    logic [RUN_W-1:0]  run_next;
    logic [WIN_W-1:0]  win;
    logic [SET_W-1:0]  settle;
    logic [LOSS_W-1:0] loss;
    logic              in_tok;
    logic              run_done;
    logic              loss_drop;

    // Run counter saturates at TOKEN_RUN so an unbroken token stream keeps completing runs every cycle.
    always_comb begin
        in_tok    = is_token(tmds_in);
        run_done  = in_tok && (run >= RUN_W'(TOKEN_RUN - 1));
        run_next  = '0;
        if (in_tok)
            run_next = run_done ? RUN_W'(TOKEN_RUN) : run + 1'b1;
        loss_drop = (state == LOCKED) && !run_done && (loss == LOSS_W'(LOSS_WINDOW - 1));
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= HUNT;
            run    <= '0;
            win    <= '0;
            settle <= '0;
            loss   <= '0;
        end else begin
            case (state)
                HUNT: begin
                    run <= run_next;
                    if (run_done) begin
                        state <= LOCKED;
                        win   <= '0;
                        loss  <= '0;
                    end else if (win == WIN_W'(WINDOW - 1)) begin
                        state <= SLIP;
                        win   <= '0;
                    end else begin
                        win <= win + 1'b1;
                    end
                end
                SLIP: begin
                    state  <= SETTLE;
                    settle <= '0;
                end
                SETTLE: begin
                    run <= '0;
                    win <= '0;
                    if (settle == SET_W'(SETTLE_CYC - 1))
                        state <= HUNT;
                    else
                        settle <= settle + 1'b1;
                end
                default: begin
                    run <= run_next;
                    if (run_done) begin
                        loss <= '0;
                    end else if (loss_drop) begin
                        state <= HUNT;
                        run   <= '0;
                        win   <= '0;
                        loss  <= '0;
                    end else begin
                        loss <= loss + 1'b1;
                    end
                end
            endcase
        end
    end

`ifdef TMDS_DEC_LOSSCNT_EN
    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n)
            loss_count <= '0;
        else if (loss_drop && (loss_count != 8'hFF))
            loss_count <= loss_count + 8'd1;
    end
`endif

    logic [9:0] in_q;
    logic       dec_tok;
    logic [1:0] dec_cd;
    logic [7:0] dec_vd;
    logic [7:0] q;
    logic [7:0] vd_comb;
    logic       out_vde;
    logic [7:0] out_vd;
    logic [1:0] out_cd;

    always_comb begin
        q          = in_q[9] ? ~in_q[7:0] : in_q[7:0];
        vd_comb    = '0;
        vd_comb[0] = q[0];
        for (int unsigned i = 1; i < 8; i++)
            vd_comb[i] = in_q[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    end

    always_ff @(posedge pixclk or negedge rst_n) begin
        if (!rst_n) begin
            in_q    <= '0;
            dec_tok <= 1'b0;
            dec_cd  <= '0;
            dec_vd  <= '0;
            out_vde <= 1'b0;
            out_vd  <= '0;
            out_cd  <= '0;
        end else begin
            in_q    <= tmds_in;
            dec_tok <= is_token(in_q);
            dec_cd  <= token_cd(in_q);
            dec_vd  <= vd_comb;
            out_vde <= ~dec_tok;
            out_vd  <= dec_tok ? 8'h00 : dec_vd;
            if (dec_tok)
                out_cd <= dec_cd;
        end
    end

    // Outputs are gated by the live state, so they follow lock changes without flushing the pipeline.
    assign locked  = (state == LOCKED);
    assign bitslip = (state == SLIP);
    assign VDE     = locked & out_vde;
    assign VD      = locked ? out_vd : 8'h00;
    assign CD      = locked ? out_cd : 2'b00;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed self-checking bench for tmds_decoder using shortened search/loss windows.
`timescale 1ns/1ps
module tb_tmds_decoder;

    localparam int WIN = 64;
    localparam int RUNL = 8;
    localparam int SETL = 16;
    localparam int LOSSW = 256;

    localparam logic [9:0] T0 = 10'b1101010100;
    localparam logic [9:0] T1 = 10'b0010101011;
    localparam logic [9:0] T2 = 10'b0101010100;
    localparam logic [9:0] T3 = 10'b1010101011;
    localparam logic [9:0] D0 = 10'b0100000000;

    logic       pixclk = 1'b0;
    logic       rst_n  = 1'b0;
    logic [9:0] tmds_in = '0;
    logic       bitslip;
    logic       locked;
    logic [7:0] VD;
    logic [1:0] CD;
    logic       VDE;
`ifdef TMDS_DEC_LOSSCNT_EN
    logic [7:0] loss_count;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tmds_decoder #(
        .WINDOW(WIN),
        .TOKEN_RUN(RUNL),
        .SETTLE_CYC(SETL),
        .LOSS_WINDOW(LOSSW)
    ) dut (
        .pixclk(pixclk),
        .rst_n(rst_n),
        .tmds_in(tmds_in),
        .bitslip(bitslip),
        .locked(locked),
        .VD(VD),
        .CD(CD),
        .VDE(VDE)
`ifdef TMDS_DEC_LOSSCNT_EN
        ,
        .loss_count(loss_count)
`endif
    );

    always #5 pixclk = ~pixclk;

    task automatic step();
        @(posedge pixclk);
        #1;
    endtask

    function automatic logic [9:0] rot(input logic [9:0] t, input int k);
        logic [9:0] r;
        for (int i = 0; i < 10; i++) r[i] = t[(i + k) % 10];
        return r;
    endfunction

    // Leaves rst_n released just after an edge so the next edge is the first HUNT cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        tmds_in = T0;
        rst_n = 1'b0;
        step();
        step();
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked got=%b exp=0", locked); end
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL reset_bitslip got=%b exp=0", bitslip); end
        n_checks++; if (VDE !== 1'b0) begin n_fail++; $display("FAIL reset_vde got=%b exp=0", VDE); end
        n_checks++; if (VD !== 8'h00) begin n_fail++; $display("FAIL reset_vd got=%h exp=00", VD); end
        n_checks++; if (CD !== 2'b00) begin n_fail++; $display("FAIL reset_cd got=%b exp=00", CD); end
`ifdef TMDS_DEC_LOSSCNT_EN
        n_checks++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL reset_losscnt got=%0d exp=0", loss_count); end
`endif
        rst_n = 1'b1;
    endtask

    task automatic test_lock();
        for (int i = 0; i < RUNL; i++) begin
            tmds_in = T0;
            step();
            if (i == RUNL - 2) begin
                n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL lock_early got=%b exp=0", locked); end
            end
        end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_after_run got=%b exp=1", locked); end
        n_checks++; if (VDE !== 1'b0) begin n_fail++; $display("FAIL lock_vde got=%b exp=0", VDE); end
        n_checks++; if (CD !== 2'b00) begin n_fail++; $display("FAIL lock_cd got=%b exp=00", CD); end
        n_checks++; if (bitslip !== 1'b0) begin n_fail++; $display("FAIL lock_bitslip got=%b exp=0", bitslip); end
    endtask

    task automatic test_tokens();
        logic [9:0] toks [4] = '{T0, T1, T2, T3};
        logic [1:0] cds  [4] = '{2'b00, 2'b01, 2'b10, 2'b11};
        for (int k = 0; k < 4; k++) begin
            tmds_in = toks[k];
            step();
            step();
            step();
            n_checks++; if (CD !== cds[k]) begin n_fail++; $display("FAIL token_cd k=%0d got=%b exp=%b", k, CD, cds[k]); end
            n_checks++; if (VDE !== 1'b0 || VD !== 8'h00) begin n_fail++; $display("FAIL token_vde_vd k=%0d got=%b/%h exp=0/00", k, VDE, VD); end
        end
    endtask

    task automatic test_data_decode();
        logic [9:0] syms [6] = '{10'b0100000000, 10'b1011111111, 10'b0100001111,
                                 10'b0000000000, 10'b1100000000, 10'b0000001111};
        logic [7:0] exps [6] = '{8'h00, 8'hFE, 8'h11, 8'hFE, 8'h01, 8'hEF};
        for (int k = 0; k < 6; k++) begin
            tmds_in = T1;
            step();
            tmds_in = syms[k];
            step();
            tmds_in = T0;
            step();
            n_checks++; if (VDE !== 1'b0 || CD !== 2'b01) begin n_fail++; $display("FAIL data_latency1 k=%0d vde=%b cd=%b exp 0/01", k, VDE, CD); end
            step();
            n_checks++; if (VDE !== 1'b1) begin n_fail++; $display("FAIL data_vde k=%0d got=%b exp=1", k, VDE); end
            n_checks++; if (VD !== exps[k]) begin n_fail++; $display("FAIL data_vd k=%0d got=%h exp=%h", k, VD, exps[k]); end
            n_checks++; if (CD !== 2'b01) begin n_fail++; $display("FAIL data_cd_hold k=%0d got=%b exp=01", k, CD); end
        end
    endtask

    task automatic test_loss();
        for (int i = 0; i < RUNL + 2; i++) begin
            tmds_in = T0;
            step();
        end
`ifdef TMDS_DEC_LOSSCNT_EN
        n_checks++; if (loss_count !== 8'd0) begin n_fail++; $display("FAIL losscnt_before got=%0d exp=0", loss_count); end
`endif
        tmds_in = D0;
        for (int k = 1; k <= LOSSW; k++) begin
            step();
            if (k == LOSSW - 1) begin
                n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL loss_early got=%b exp=1", locked); end
            end
        end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL loss_unlock got=%b exp=0", locked); end
        n_checks++; if (VDE !== 1'b0 || VD !== 8'h00) begin n_fail++; $display("FAIL loss_outputs got=%b/%h exp=0/00", VDE, VD); end
`ifdef TMDS_DEC_LOSSCNT_EN
        n_checks++; if (loss_count !== 8'd1) begin n_fail++; $display("FAIL losscnt_after got=%0d exp=1", loss_count); end
`endif
    endtask

    task automatic test_reset_mid_lock();
        int pulses = 0;
        do_reset();
        for (int i = 0; i < RUNL + 2; i++) begin
            tmds_in = T0;
            step();
        end
        tmds_in = D0;
        step();
        step();
        step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (locked !== 1'b0 || VDE !== 1'b0 || VD !== 8'h00 || CD !== 2'b00 || bitslip !== 1'b0)
            begin n_fail++; $display("FAIL midreset_outputs got=%b%b/%h/%b/%b exp all 0", locked, VDE, VD, CD, bitslip); end
        step();
        rst_n = 1'b1;
        tmds_in = T0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (bitslip) pulses++;
        end
        n_checks++; if (pulses != 0) begin n_fail++; $display("FAIL midreset_no_slip got=%0d exp=0", pulses); end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL midreset_relock got=%b exp=1", locked); end
    endtask

    task automatic test_lock_wins();
        int pulses = 0;
        do_reset();
        for (int k = 1; k <= WIN; k++) begin
            tmds_in = (k >= WIN - RUNL + 1) ? T0 : D0;
            step();
            if (bitslip) pulses++;
        end
        n_checks++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lockwins_locked got=%b exp=1", locked); end
        n_checks++; if (pulses != 0 || bitslip !== 1'b0) begin n_fail++; $display("FAIL lockwins_slip got=%0d exp=0", pulses); end
        do_reset();
        for (int k = 1; k <= WIN; k++) begin
            tmds_in = (k >= WIN - RUNL + 2) ? T0 : D0;
            step();
        end
        n_checks++; if (bitslip !== 1'b1) begin n_fail++; $display("FAIL window_expire_slip got=%b exp=1", bitslip); end
        n_checks++; if (locked !== 1'b0) begin n_fail++; $display("FAIL window_expire_locked got=%b exp=0", locked); end
    endtask

    task automatic test_bitslip_search();
        int off = 3;
        int slips = 0;
        int cyc = 0;
        int slip_at [3] = '{0, 0, 0};
        bit done = 0;
        tmds_in = rot(T0, off);
        do_reset();
        while (!done && cyc < 600) begin
            tmds_in = rot(T0, off);
            step();
            cyc++;
            if (bitslip) begin
                if (slips < 3) slip_at[slips] = cyc;
                slips++;
                off = (off + 9) % 10;
            end
            if (locked) done = 1;
        end
        n_checks++; if (!done) begin n_fail++; $display("FAIL search_timeout cycles=%0d limit=600", cyc); end
        n_checks++; if (slips != 3) begin n_fail++; $display("FAIL search_slips got=%0d exp=3", slips); end
        n_checks++; if (slip_at[0] != WIN) begin n_fail++; $display("FAIL search_first_slip got=%0d exp=%0d", slip_at[0], WIN); end
        n_checks++; if (slip_at[1] - slip_at[0] != WIN + SETL + 1) begin n_fail++; $display("FAIL search_interval1 got=%0d exp=%0d", slip_at[1] - slip_at[0], WIN + SETL + 1); end
        n_checks++; if (slip_at[2] - slip_at[1] != WIN + SETL + 1) begin n_fail++; $display("FAIL search_interval2 got=%0d exp=%0d", slip_at[2] - slip_at[1], WIN + SETL + 1); end
        n_checks++; if (cyc != slip_at[2] + 1 + SETL + RUNL) begin n_fail++; $display("FAIL search_lock_cycle got=%0d exp=%0d", cyc, slip_at[2] + 1 + SETL + RUNL); end
    endtask

    initial begin
        test_reset();
        test_lock();
        test_tokens();
        test_data_decode();
        test_loss();
        test_reset_mid_lock();
        test_lock_wins();
        test_bitslip_search();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
